// File: rtl/interfaz_pkg.sv
// Shared definitions for the MIPS debug serial interfaces (transmit and receive sides).
// TX_CHECKSUM_EN adds the CHK state used by the transmit FSM.
package interfaz_pkg;

  localparam logic [7:0] TX_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_LOAD,
    ST_BYTE,
    ST_WAIT,
`ifdef TX_CHECKSUM_EN
    ST_CHK,
`endif
    ST_DONE
  } tx_state_e;

  // Remembers which byte kind is in flight so WAIT knows where to go next.
  typedef enum logic [1:0] {
    WS_HDR,
    WS_PAY,
    WS_CHK
  } wait_src_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/interfaz_tx_if.sv
// Debug-read / UART-TX handshake bundle for the transmit interface.
// slave = interfaz_tx, master = the MIPS debug port plus UART side.
interface interfaz_tx_if #(
  parameter int IDX_W = 2
);
  logic             send;
  logic [31:0]      word_in;
  logic [IDX_W-1:0] word_idx;
  logic             tx_done;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             busy;
  logic             frame_done;

  modport slave (
    input  send, word_in, tx_done,
    output word_idx, tx_start, tx_data, busy, frame_done
  );

  modport master (
    output send, word_in, tx_done,
    input  word_idx, tx_start, tx_data, busy, frame_done
  );
endinterface

// File: rtl/tx_word_shifter.sv
// 32-bit word register that hands out bytes MSB first, with a byte counter
// whose last_byte flag tells the FSM when the word is exhausted.
module tx_word_shifter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_din,
  input  logic        i_shift,
  input  logic        i_next,
  output logic [7:0]  o_top,
  output logic        o_last_byte
);

  logic [31:0] r_sh;
  logic [1:0]  r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_load) begin
        r_sh <= i_din;
      end else if (i_shift) begin
        r_sh <= {r_sh[23:0], 8'h00};
      end
      if (i_load) begin
        r_cnt <= '0;
      end else if (i_next) begin
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  assign o_top       = r_sh[31:24];
  assign o_last_byte = (r_cnt == 2'd3);

endmodule

// File: rtl/interfaz_tx.sv
// Streams a frame (0xA5 header + N_WORDS words MSB first) from the MIPS debug port
// to the UART TX core. Define TX_CHECKSUM_EN to append an XOR checksum byte.
//
// state  | meaning
// IDLE   | waiting for send; index and checksum cleared
// HEADER | tx_start with 0xA5
// LOAD   | latch word_in, clear byte counter
// BYTE   | tx_start with top byte of the word, then shift
// WAIT   | waiting for tx_done from the UART
// CHK    | tx_start with the checksum byte (TX_CHECKSUM_EN only)
// DONE   | frame_done pulse
module interfaz_tx
  import interfaz_pkg::*;
#(
  parameter int N_WORDS = 4
) (
  input  logic          clk,
  input  logic          reset,
  interfaz_tx_if.slave  bus
);

  localparam int               IDX_W    = idx_width(N_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  tx_state_e        r_state;
  wait_src_e        r_wsrc;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;
  logic [IDX_W-1:0] r_word_idx;
  logic             r_busy;
  logic             r_frame_done;
`ifdef TX_CHECKSUM_EN
  logic [7:0]       r_chk;
`endif

  logic       w_load;
  logic       w_shift;
  logic       w_next;
  logic [7:0] w_top;
  logic       w_last_byte;

  assign w_load  = (r_state == ST_LOAD);
  assign w_shift = (r_state == ST_BYTE);
  assign w_next  = (r_state == ST_WAIT) && bus.tx_done &&
                   (r_wsrc == WS_PAY) && !w_last_byte;

  tx_word_shifter u_shifter (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_load      (w_load),
    .i_din       (bus.word_in),
    .i_shift     (w_shift),
    .i_next      (w_next),
    .o_top       (w_top),
    .o_last_byte (w_last_byte)
  );

  // Outputs are registered on the edge entering each state, so tx_start/tx_data
  // line up with HEADER, BYTE and CHK; LOAD forwards word_in's top byte directly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_wsrc       <= WS_HDR;
      r_tx_start   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_word_idx   <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef TX_CHECKSUM_EN
      r_chk        <= 8'h00;
`endif
    end else begin
      r_tx_start   <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_word_idx <= '0;
          r_busy     <= 1'b0;
`ifdef TX_CHECKSUM_EN
          r_chk      <= 8'h00;
`endif
          if (bus.send) begin
            r_state    <= ST_HEADER;
            r_tx_start <= 1'b1;
            r_tx_data  <= TX_HEADER;
            r_busy     <= 1'b1;
          end
        end
        ST_HEADER: begin
          r_wsrc  <= WS_HDR;
          r_state <= ST_WAIT;
        end
        ST_LOAD: begin
          r_tx_start <= 1'b1;
          r_tx_data  <= bus.word_in[31:24];
`ifdef TX_CHECKSUM_EN
          r_chk      <= r_chk ^ bus.word_in[31:24];
`endif
          r_state    <= ST_BYTE;
        end
        ST_BYTE: begin
          r_wsrc  <= WS_PAY;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.tx_done) begin
            case (r_wsrc)
              WS_HDR: r_state <= ST_LOAD;
              WS_PAY: begin
                if (!w_last_byte) begin
                  r_tx_start <= 1'b1;
                  r_tx_data  <= w_top;
`ifdef TX_CHECKSUM_EN
                  r_chk      <= r_chk ^ w_top;
`endif
                  r_state    <= ST_BYTE;
                end else if (r_word_idx != LAST_IDX) begin
                  r_word_idx <= r_word_idx + 1'b1;
                  r_state    <= ST_LOAD;
                end else begin
`ifdef TX_CHECKSUM_EN
                  r_tx_start <= 1'b1;
                  r_tx_data  <= r_chk;
                  r_state    <= ST_CHK;
`else
                  r_frame_done <= 1'b1;
                  r_state      <= ST_DONE;
`endif
                end
              end
              default: begin
                r_frame_done <= 1'b1;
                r_state      <= ST_DONE;
              end
            endcase
          end
        end
`ifdef TX_CHECKSUM_EN
        ST_CHK: begin
          r_wsrc  <= WS_CHK;
          r_state <= ST_WAIT;
        end
`endif
        ST_DONE: begin
          r_busy     <= 1'b0;
          r_word_idx <= '0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_start   = r_tx_start;
  assign bus.tx_data    = r_tx_data;
  assign bus.word_idx   = r_word_idx;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;

endmodule
